// File: rtl/simplerisc_pkg.sv
// ----------------------------------------------------------------------------
// simplerisc_pkg
//   Shared definitions for the SimpleRisc core: datapath widths, the major
//   opcode values that front-end stages care about, and the fetch FSM states.
// ----------------------------------------------------------------------------
package simplerisc_pkg;

    localparam int XLEN   = 32;   // data/address width
    localparam int INST_W = 32;   // instruction word width
    localparam int OPC_W  = 5;    // major opcode field width

    // Control-flow and filler opcodes (inst[31:27])
    localparam logic [OPC_W-1:0] OPC_NOP  = 5'b01101;
    localparam logic [OPC_W-1:0] OPC_B    = 5'b10010;
    localparam logic [OPC_W-1:0] OPC_CALL = 5'b10011;
    localparam logic [OPC_W-1:0] OPC_RET  = 5'b10100;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage of the single-cycle SimpleRisc core. Holds the PC,
//   requests one instruction at a time from instruction memory over a
//   req/ready handshake, and holds it (with its {I,opcode} field) for decode
//   until execute commits it. A memory that never answers within
//   IMEM_TIMEOUT request cycles raises a sticky fetch_err and halts the unit.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   imem_req/addr/ready/rdata  instruction-memory handshake (addr == pc)
//   inst, opcode_and_I         current instruction and {inst[26], inst[31:27]}
//   inst_valid, pc             instruction-valid flag and its address
//   commit, branch_taken,      execute finished inst; optional redirect
//   branch_pc                    target (low two bits forced to zero)
//   halt_req, halted           stop after the current commit / unit halted
//   fetch_err                  sticky instruction-memory timeout flag
// ----------------------------------------------------------------------------
module fetch_unit
    import simplerisc_pkg::*;
#(
    parameter int               XLEN         = simplerisc_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC     = '0,
    parameter int               IMEM_TIMEOUT = 15   // legal range 1..255
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_ready,
    input  logic [INST_W-1:0]   imem_rdata,
    output logic [INST_W-1:0]   inst,
    output logic [OPC_W:0]      opcode_and_I,
    output logic                inst_valid,
    output logic [XLEN-1:0]     pc,
    input  logic                commit,
    input  logic                branch_taken,
    input  logic [XLEN-1:0]     branch_pc,
    input  logic                halt_req,
    output logic                halted,
    output logic                fetch_err
);

    localparam logic [7:0] LAST_WAIT = 8'(IMEM_TIMEOUT - 1);

    fetch_state_t state;
    logic [7:0]   wait_cnt;    // request cycles already spent without ready

    assign imem_addr = pc;

    // NOTE: all state and registered outputs update with non-blocking
    // assignments so every branch below sees the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            imem_req     <= 1'b0;
            inst         <= '0;
            opcode_and_I <= '0;
            inst_valid   <= 1'b0;
            halted       <= 1'b0;
            fetch_err    <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (!imem_req) begin
                        // First cycle after reset: raise the request; no
                        // handshake can happen until it is visible.
                        imem_req <= 1'b1;
                    end else if (imem_ready) begin
                        // Ready has priority over the timeout, so an answer on
                        // the last permitted cycle is still accepted.
                        inst         <= imem_rdata;
                        opcode_and_I <= {imem_rdata[26], imem_rdata[31:27]};
                        inst_valid   <= 1'b1;
                        imem_req     <= 1'b0;
                        wait_cnt     <= '0;
                        state        <= EXEC;
                    end else if (wait_cnt == LAST_WAIT) begin
                        fetch_err <= 1'b1;
                        halted    <= 1'b1;
                        imem_req  <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                EXEC: begin
                    // halt_req only takes effect together with commit, so an
                    // instruction in execute is never abandoned.
                    if (commit) begin
                        pc         <= branch_taken ? (branch_pc & ~XLEN'(3))
                                                   : pc + XLEN'(4);
                        inst_valid <= 1'b0;
                        if (halt_req) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end

                HALT: begin
                    // Only reset leaves HALT.
                end

                default: begin
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                    halted     <= 1'b1;
                    state      <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. Inputs are driven and outputs sampled on
//   the falling clock edge; the DUT acts on the rising edge.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;
    logic [31:0]     inst;
    logic [5:0]      opcode_and_I;
    logic            inst_valid;
    logic [XLEN-1:0] pc;
    logic            commit;
    logic            branch_taken;
    logic [XLEN-1:0] branch_pc;
    logic            halt_req;
    logic            halted;
    logic            fetch_err;

    int vectors     = 0;
    int miscompares = 0;

    fetch_unit #(
        .XLEN         (XLEN),
        .RESET_PC     ('0),
        .IMEM_TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .opcode_and_I (opcode_and_I),
        .inst_valid   (inst_valid),
        .pc           (pc),
        .commit       (commit),
        .branch_taken (branch_taken),
        .branch_pc    (branch_pc),
        .halt_req     (halt_req),
        .halted       (halted),
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        imem_ready   = 1'b0;
        imem_rdata   = '0;
        commit       = 1'b0;
        branch_taken = 1'b0;
        branch_pc    = '0;
        halt_req     = 1'b0;
    endtask

    // Assert reset, hold two cycles, release on a falling edge.
    task automatic apply_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One-cycle handshake from FETCH with the request already raised.
    task automatic give_inst(input logic [31:0] word);
        imem_ready = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ready = 1'b0;
    endtask

    task automatic do_commit(input logic taken, input logic [XLEN-1:0] target);
        commit       = 1'b1;
        branch_taken = taken;
        branch_pc    = target;
        @(negedge clk);
        commit       = 1'b0;
        branch_taken = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_pc",        pc,           0);
        check("rst_req",       imem_req,     0);
        check("rst_valid",     inst_valid,   0);
        check("rst_halted",    halted,       0);
        check("rst_err",       fetch_err,    0);
        check("rst_inst",      inst,         0);
        check("rst_opc",       opcode_and_I, 0);

        // ---- 1: back-to-back instructions, ready and commit held high ----
        @(negedge clk);
        check("t1_req_rise", imem_req, 1);
        for (int k = 0; k < 8; k++) begin
            check("t1_valid", inst_valid, (k % 2));
            check("t1_pc",    pc,         4 * (k / 2));
            if (k == 0) begin
                imem_rdata = 32'h1000_0000;
                imem_ready = 1'b1;
                commit     = 1'b1;
            end
            if (k < 7) @(negedge clk);
        end
        imem_ready = 1'b0;
        commit     = 1'b0;
        do_commit(1'b0, '0);                 // pc 12 -> 16
        check("t1_pc16",  pc,       32'h10);
        check("t1_req16", imem_req, 1);

        // ---- 2: instruction decode field, held stable until commit ----
        give_inst(32'h6C00_0000);
        check("t2_valid", inst_valid,   1);
        check("t2_inst",  inst,         32'h6C00_0000);
        check("t2_opc",   opcode_and_I, 6'b101101);
        check("t2_req",   imem_req,     0);
        imem_ready   = 1'b1;                 // ignored outside FETCH
        imem_rdata   = 32'hDEAD_BEEF;
        branch_taken = 1'b1;                 // no effect without commit
        branch_pc    = 32'h200;
        repeat (3) begin
            @(negedge clk);
            check("t2_hold_inst",  inst,       32'h6C00_0000);
            check("t2_hold_valid", inst_valid, 1);
            check("t2_hold_pc",    pc,         32'h10);
        end
        clear_inputs();

        // ---- 3: branch with unaligned target, and PC wrap ----
        do_commit(1'b1, 32'h103);
        check("t3_br_addr",  imem_addr,  32'h100);
        check("t3_br_req",   imem_req,   1);
        check("t3_br_valid", inst_valid, 0);
        give_inst(32'h4C00_0000);
        check("t3_mov_opc", opcode_and_I, 6'b101001);
        do_commit(1'b1, 32'hFFFF_FFFE);
        check("t3_top_pc", pc, 32'hFFFF_FFFC);
        give_inst(32'h6800_0000);
        check("t3_nop_opc", opcode_and_I, 6'b001101);
        do_commit(1'b0, '0);
        check("t3_wrap_pc",  pc,       0);
        check("t3_wrap_req", imem_req, 1);

        // ---- 5: halt request pending until commit ----
        give_inst(32'h9000_0000);
        check("t5_valid", inst_valid, 1);
        halt_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t5_wait_halted", halted,     0);
            check("t5_wait_valid",  inst_valid, 1);
            check("t5_wait_req",    imem_req,   0);
        end
        do_commit(1'b0, '0);
        halt_req = 1'b0;
        check("t5_pc",     pc,         4);
        check("t5_halted", halted,     1);
        check("t5_valid0", inst_valid, 0);
        check("t5_req0",   imem_req,   0);
        imem_ready = 1'b1;
        commit     = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("t5_stay_req", imem_req, 0);
            check("t5_stay_pc",  pc,       4);
        end
        clear_inputs();

        // ---- 4: instruction-memory timeout ----
        apply_reset();
        @(negedge clk);                      // first request cycle
        for (int j = 0; j < 15; j++) begin
            check("t4_no_err", fetch_err, 0);
            check("t4_req",    imem_req,  1);
            @(negedge clk);
        end
        check("t4_err",    fetch_err, 1);
        check("t4_halted", halted,    1);
        check("t4_req0",   imem_req,  0);
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        commit     = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_stuck_err",   fetch_err,  1);
        check("t4_stuck_halt",  halted,     1);
        check("t4_stuck_valid", inst_valid, 0);
        check("t4_stuck_pc",    pc,         0);
        check("t4_stuck_req",   imem_req,   0);
        clear_inputs();

        // Ready on the last permitted wait cycle is accepted.
        apply_reset();
        @(negedge clk);
        repeat (14) @(negedge clk);
        check("t4_late_req", imem_req, 1);
        give_inst(32'hCAFE_0001);
        check("t4_late_valid", inst_valid, 1);
        check("t4_late_err",   fetch_err,  0);
        check("t4_late_halt",  halted,     0);
        check("t4_late_inst",  inst,       32'hCAFE_0001);
        // The wait counter starts over for the next fetch.
        do_commit(1'b0, '0);
        repeat (14) @(negedge clk);
        check("t4_again_no_err", fetch_err, 0);
        @(negedge clk);
        check("t4_again_err", fetch_err, 1);

        // ---- 6: asynchronous reset mid-FETCH and mid-EXEC ----
        apply_reset();
        @(negedge clk);
        check("t6_fetch_req", imem_req, 1);
        #2 reset = 1'b1;
        #1;
        check("t6_fetch_rst_req", imem_req, 0);
        check("t6_fetch_rst_pc",  pc,       0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t6_resume_req", imem_req, 1);
        give_inst(32'h1111_1111);
        do_commit(1'b0, '0);
        give_inst(32'h2222_2222);
        check("t6_exec_pc",    pc,         4);
        check("t6_exec_valid", inst_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("t6_exec_rst_valid", inst_valid,   0);
        check("t6_exec_rst_inst",  inst,         0);
        check("t6_exec_rst_opc",   opcode_and_I, 0);
        check("t6_exec_rst_pc",    pc,           0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t6_exec_resume_req",  imem_req,  1);
        check("t6_exec_resume_addr", imem_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
